// File: rtl/sinus_period_meter_pkg.sv
// Shared definitions for the sine-period meter: measurement states and the
// default sample width / arming threshold used by the test-signal generators.
package sinus_period_meter_pkg;

  // Sample width of the test-signal stream.
  localparam int DATA_W_DEFAULT = 24;

  // Arming threshold (2^21, a quarter of full scale) as a 24-bit constant.
  localparam logic [23:0] HYST_DEFAULT = 24'd2097152;

  // Measurement state: waiting for the first crossing, or timing a period.
  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

endpackage

// File: rtl/sinus_period_meter_zero_cross_det.sv
// Rising zero-crossing detector with hysteresis. The detector arms only after
// a sample drops below -HYST, so small negative dips (harmonic contamination)
// followed by a return to >= 0 do not produce a crossing.
module zero_cross_det
  import sinus_period_meter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int HYST   = int'(HYST_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     data_valid,
  input  logic                     clear,
  output logic                     crossing
);

  localparam int                       NEG_HYST_I = -HYST;
  localparam logic signed [DATA_W-1:0] NEG_HYST   = NEG_HYST_I[DATA_W-1:0];

  logic armed_q;

  // A crossing is any non-negative valid sample seen while armed.
  assign crossing = armed_q && data_valid && !data_in[DATA_W-1];

  // Arm on a deep negative sample; disarm when the crossing fires or on clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      armed_q <= 1'b0;
    end else if (data_valid) begin
      if (data_in < NEG_HYST) begin
        armed_q <= 1'b1;
      end else if (crossing) begin
        armed_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sinus_period_meter.sv
// Period meter for a signed sine test stream. Between consecutive accepted
// rising crossings it counts samples and clocks and tracks the signed peak
// values; results are published as a registered set with a one-cycle strobe.
module sinus_period_meter
  import sinus_period_meter_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int HYST       = int'(HYST_DEFAULT),
  parameter int CNT_W      = 8,
  parameter int MAX_PERIOD = 255,
  parameter int CLK_W      = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     data_valid,
  output logic        [CNT_W-1:0]  period_samples,
  output logic        [CLK_W-1:0]  period_clocks,
  output logic signed [DATA_W-1:0] peak_max,
  output logic signed [DATA_W-1:0] peak_min,
  output logic                     result_valid,
  output logic                     locked,
  output logic                     timeout
);

  localparam logic [CNT_W:0] MAX_P = (CNT_W + 1)'(MAX_PERIOD);

  state_e                     state_q;
  logic        [CNT_W-1:0]    cnt_q;
  logic        [CLK_W-1:0]    clk_cnt_q;
  logic signed [DATA_W-1:0]   run_max_q;
  logic signed [DATA_W-1:0]   run_min_q;
  logic        [CNT_W-1:0]    period_samples_q;
  logic        [CLK_W-1:0]    period_clocks_q;
  logic signed [DATA_W-1:0]   peak_max_q;
  logic signed [DATA_W-1:0]   peak_min_q;
  logic                       result_valid_q;
  logic                       locked_q;
  logic                       timeout_q;

  logic                       crossing;
  logic                       timeout_hit;
  logic        [CNT_W:0]      cnt_inc;

  // Clock counts stick at all-ones rather than wrapping.
  function automatic logic [CLK_W-1:0] sat_inc(input logic [CLK_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  zero_cross_det #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_det (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .clear      (timeout_hit),
    .crossing   (crossing)
  );

  // Timeout when this non-crossing sample would bring the count to MAX_PERIOD.
  assign cnt_inc     = {1'b0, cnt_q} + 1'b1;
  assign timeout_hit = (state_q == MEASURE) && data_valid && !crossing &&
                       (cnt_inc >= MAX_P);

  // Measurement FSM with all counters, running peaks and registered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      clk_cnt_q        <= '0;
      run_max_q        <= '0;
      run_min_q        <= '0;
      period_samples_q <= '0;
      period_clocks_q  <= '0;
      peak_max_q       <= '0;
      peak_min_q       <= '0;
      result_valid_q   <= 1'b0;
      locked_q         <= 1'b0;
      timeout_q        <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (crossing) begin
            state_q   <= MEASURE;
            cnt_q     <= '0;
            clk_cnt_q <= '0;
            run_max_q <= data_in;
            run_min_q <= data_in;
          end
        end
        MEASURE: begin
          if (crossing) begin
            // The crossing sample closes this period and opens the next one.
            period_samples_q <= cnt_inc[CNT_W-1:0];
            period_clocks_q  <= sat_inc(clk_cnt_q);
            peak_max_q       <= run_max_q;
            peak_min_q       <= run_min_q;
            result_valid_q   <= 1'b1;
            locked_q         <= 1'b1;
            cnt_q            <= '0;
            clk_cnt_q        <= '0;
            run_max_q        <= data_in;
            run_min_q        <= data_in;
          end else begin
            clk_cnt_q <= sat_inc(clk_cnt_q);
            if (timeout_hit) begin
              timeout_q <= 1'b1;
              locked_q  <= 1'b0;
              cnt_q     <= '0;
              state_q   <= IDLE;
            end else if (data_valid) begin
              cnt_q <= cnt_inc[CNT_W-1:0];
              if (data_in > run_max_q) run_max_q <= data_in;
              if (data_in < run_min_q) run_min_q <= data_in;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign period_samples = period_samples_q;
  assign period_clocks  = period_clocks_q;
  assign peak_max       = peak_max_q;
  assign peak_min       = peak_min_q;
  assign result_valid   = result_valid_q;
  assign locked         = locked_q;
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_sinus_period_meter.sv
// Directed bench for sinus_period_meter: a 40-sample contaminated sine with a
// secondary shallow crossing at index 20 and the main crossing at index 38.
// A second instance with an 8-bit clock counter exercises saturation.
module tb_sinus_period_meter;

  logic        clk;
  logic        reset;
  logic [23:0] data_in;
  logic        data_valid;

  logic [7:0]  period_samples;
  logic [23:0] period_clocks;
  logic [23:0] peak_max;
  logic [23:0] peak_min;
  logic        result_valid;
  logic        locked;
  logic        timeout;

  logic [7:0]  s_period_samples;
  logic [7:0]  s_period_clocks;
  logic [23:0] s_peak_max;
  logic [23:0] s_peak_min;
  logic        s_result_valid;
  logic        s_locked;
  logic        s_timeout;

  int n_cmp;
  int n_bad;
  int rv_total;
  int to_total;
  int s_rv_total;
  int s_to_total;
  int rv_idx[$];

  logic signed [23:0] tbl [40];

  localparam logic [23:0] EXP_MAX = 24'h79E68B;  //  7988875
  localparam logic [23:0] EXP_MIN = 24'h861975;  // -7988875

  sinus_period_meter u_dut (
    .clk            (clk),
    .reset          (reset),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .period_samples (period_samples),
    .period_clocks  (period_clocks),
    .peak_max       (peak_max),
    .peak_min       (peak_min),
    .result_valid   (result_valid),
    .locked         (locked),
    .timeout        (timeout)
  );

  sinus_period_meter #(.CLK_W(8)) u_sat (
    .clk            (clk),
    .reset          (reset),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .period_samples (s_period_samples),
    .period_clocks  (s_period_clocks),
    .peak_max       (s_peak_max),
    .peak_min       (s_peak_min),
    .result_valid   (s_result_valid),
    .locked         (s_locked),
    .timeout        (s_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (result_valid)   rv_total++;
    if (timeout)        to_total++;
    if (s_result_valid) s_rv_total++;
    if (s_timeout)      s_to_total++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One strobe, then idle until gap clocks have elapsed since the strobe.
  task automatic send(input logic [23:0] d, input int gap, output logic rv, output logic to);
    @(negedge clk);
    data_valid = 1'b1;
    data_in    = d;
    @(negedge clk);
    data_valid = 1'b0;
    rv         = result_valid;
    to         = timeout;
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic run_table(input int first, input int last, input int gap);
    logic rv, to;
    rv_idx.delete();
    for (int i = first; i <= last; i++) begin
      send(tbl[i], gap, rv, to);
      if (rv) rv_idx.push_back(i);
    end
  endtask

  task automatic check_results(input string tag, input logic [23:0] clocks);
    check_eq({tag, "_samples"}, 64'(period_samples), 64'd40);
    check_eq({tag, "_clocks"},  64'(period_clocks),  64'(clocks));
    check_eq({tag, "_max"},     64'(peak_max),       64'(EXP_MAX));
    check_eq({tag, "_min"},     64'(peak_min),       64'(EXP_MIN));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_samples"}, 64'(period_samples), 64'd0);
    check_eq({tag, "_clocks"},  64'(period_clocks),  64'd0);
    check_eq({tag, "_max"},     64'(peak_max),       64'd0);
    check_eq({tag, "_min"},     64'(peak_min),       64'd0);
    check_eq({tag, "_locked"},  64'(locked),         64'd0);
  endtask

  initial begin
    logic rv, to;
    int   rv_before;
    n_cmp = 0; n_bad = 0;
    rv_total = 0; to_total = 0; s_rv_total = 0; s_to_total = 0;
    tbl = '{ 24'sd3000000,  24'sd5000000,  24'sd6500000,  24'sd7500000,
             24'sd7988875,  24'sd7600000,  24'sd7000000,  24'sd6000000,
             24'sd5000000,  24'sd4000000,  24'sd3200000,  24'sd2500000,
             24'sd1900000,  24'sd1400000,  24'sd900000,   24'sd500000,
             24'sd100000,  -24'sd300000,  -24'sd600000,  -24'sd200000,
             24'sd200000,  -24'sd2500000, -24'sd4000000, -24'sd5500000,
            -24'sd6800000, -24'sd7600000, -24'sd7988875, -24'sd7700000,
            -24'sd7000000, -24'sd6000000, -24'sd5000000, -24'sd4000000,
            -24'sd3000000, -24'sd2200000, -24'sd1500000, -24'sd900000,
            -24'sd500000,  -24'sd100000,   24'sd0,       24'sd1200000 };

    // Reset held with data_valid toggling on a deep-negative then positive value.
    reset = 1'b1; data_valid = 1'b0; data_in = 24'h800001;
    repeat (3) begin
      @(negedge clk);
      data_valid = ~data_valid;
      data_in    = data_valid ? 24'h800001 : 24'h000100;
    end
    @(negedge clk);
    reset = 1'b0; data_valid = 1'b0; data_in = '0;
    @(negedge clk);
    check_zero("reset");
    check_eq("reset_rv",      64'(result_valid), 64'd0);
    check_eq("reset_timeout", 64'(timeout),      64'd0);
    check_eq("reset_pulses",  64'(rv_total + to_total), 64'd0);

    // First pass only arms and finds the first crossing: nothing published.
    run_table(0, 39, 4);
    check_eq("loop1_rv_count", 64'(rv_idx.size()), 64'd0);
    check_eq("loop1_locked",   64'(locked),        64'd0);

    run_table(0, 39, 4);
    check_eq("loop2_rv_count", 64'(rv_idx.size()), 64'd1);
    if (rv_idx.size() == 1) check_eq("loop2_rv_idx", 64'(rv_idx[0]), 64'd38);
    check_eq("loop2_locked", 64'(locked), 64'd1);
    check_results("loop2", 24'd160);
    check_eq("loop2_sat_clocks", 64'(s_period_clocks), 64'd160);

    // Stop right at the main crossing so the timeout count starts from it.
    run_table(0, 38, 4);
    check_eq("loop3_rv_count", 64'(rv_idx.size()), 64'd1);
    if (rv_idx.size() == 1) check_eq("loop3_rv_idx", 64'(rv_idx[0]), 64'd38);
    check_results("loop3", 24'd160);

    // Hold a small positive value: timeout on the 255th sample after the crossing.
    for (int i = 1; i <= 254; i++) send(24'd1000, 4, rv, to);
    check_eq("pre_timeout_count",  64'(to_total), 64'd0);
    check_eq("pre_timeout_locked", 64'(locked),   64'd1);
    send(24'd1000, 4, rv, to);
    check_eq("timeout_pulse",  64'(to),       64'd1);
    check_eq("timeout_locked", 64'(locked),   64'd0);
    check_results("timeout_hold", 24'd160);
    send(24'd1000, 4, rv, to);
    check_eq("post_timeout_count", 64'(to_total), 64'd1);

    // Reacquire, then reset in the middle of a period at index 10.
    run_table(0, 39, 4);
    check_eq("reacq1_rv_count", 64'(rv_idx.size()), 64'd0);
    run_table(0, 39, 4);
    check_eq("reacq2_rv_count", 64'(rv_idx.size()), 64'd1);
    check_eq("reacq2_locked",   64'(locked),        64'd1);
    run_table(0, 9, 4);
    @(negedge clk);
    reset = 1'b1; data_valid = 1'b1; data_in = tbl[10];
    @(negedge clk);
    reset = 1'b0; data_valid = 1'b0;
    check_zero("midreset");
    rv_before = rv_total;
    run_table(11, 39, 4);
    check_eq("resume_first_cross_rv", 64'(rv_total - rv_before), 64'd0);
    run_table(0, 39, 4);
    check_eq("resume_second_cross_rv", 64'(rv_idx.size()), 64'd1);
    if (rv_idx.size() == 1) check_eq("resume_rv_idx", 64'(rv_idx[0]), 64'd38);
    check_results("resume", 24'd160);

    // Sparse strobes: 40 samples x 7 clocks = 280, which saturates an 8-bit counter.
    run_table(0, 39, 7);
    run_table(0, 39, 7);
    check_eq("sparse_rv_count", 64'(rv_idx.size()), 64'd1);
    check_results("sparse", 24'd280);
    check_eq("sat_samples", 64'(s_period_samples), 64'd40);
    check_eq("sat_clocks",  64'(s_period_clocks),  64'd255);
    check_eq("sat_max",     64'(s_peak_max),       64'(EXP_MAX));
    check_eq("sat_min",     64'(s_peak_min),       64'(EXP_MIN));
    check_eq("sat_locked",  64'(s_locked),         64'd1);
    check_eq("sat_rv_total", 64'(s_rv_total), 64'(rv_total));
    check_eq("sat_to_total", 64'(s_to_total), 64'(to_total));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
